mem_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch requester and the load/store requester, so the core can move from split imem/data_mem to one memory. The arbiter sits between the processor datapath and the memory. It allows one outstanding transaction at a time and uses round-robin arbitration. It also runs a response watchdog that returns an error instead of hanging the core.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_rr.sv | 24 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester identity
// and the reset value of the round-robin pointer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Fetch wins the very first tie after reset.
    localparam owner_t RESET_LAST_GRANT = OWN_DM;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin pick: a lone requester wins, on a tie the one that
// was not granted last wins. Purely combinational.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       if_valid,
    input  logic       dm_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // grant[0] selects fetch, grant[1] selects load/store.
    always_comb begin
        grant = 2'b00;
        if (if_valid && dm_valid) begin
            grant = (last_grant == OWN_DM) ? 2'b01 : 2'b10;
        end else if (if_valid) begin
            grant = 2'b01;
        end else if (dm_valid) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store with
// round-robin arbitration, one outstanding transaction and a response watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,

    input  logic                dm_req_valid,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_req_ready,
    output logic                dm_rsp_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t          state;
    owner_t              owner;
    owner_t              last_grant;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W/8-1:0] lat_wstrb;
    logic [CNT_W-1:0]    wd_cnt;

    logic [1:0] grant;
    logic       in_idle;
    logic       in_wait;
    logic       wd_fire;
    logic       rsp_any;
    logic       rsp_data;

    mem_arb_rr u_rr (
        .if_valid   (if_req_valid),
        .dm_valid   (dm_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= RESET_LAST_GRANT;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
            wd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[0]) begin
                        lat_we     <= 1'b0;
                        lat_addr   <= if_addr;
                        lat_wdata  <= '0;
                        lat_wstrb  <= '0;
                        owner      <= OWN_IF;
                        last_grant <= OWN_IF;
                        state      <= REQ;
                    end else if (grant[1]) begin
                        lat_we     <= dm_we;
                        lat_addr   <= dm_addr;
                        lat_wdata  <= dm_wdata;
                        lat_wstrb  <= dm_wstrb;
                        owner      <= OWN_DM;
                        last_grant <= OWN_DM;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        wd_cnt <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid || wd_fire) begin
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_idle = (state == IDLE);
    assign in_wait = (state == WAIT);

    // The counter holds the number of silent WAIT cycles already seen, so the
    // watchdog fires on the TIMEOUT-th silent cycle; a real response wins a tie.
    assign wd_fire  = in_wait && !mem_rsp_valid && (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_data = in_wait && mem_rsp_valid;
    assign rsp_any  = rsp_data || wd_fire;

    assign if_req_ready = in_idle && grant[0];
    assign dm_req_ready = in_idle && grant[1];

    assign mem_req_valid = (state == REQ);
    assign mem_we        = lat_we;
    assign mem_addr      = lat_addr;
    assign mem_wdata     = lat_wdata;
    assign mem_wstrb     = lat_wstrb;

    assign if_rsp_valid = rsp_any && (owner == OWN_IF);
    assign if_err       = wd_fire && (owner == OWN_IF);
    assign if_rdata     = (rsp_data && (owner == OWN_IF)) ? mem_rdata : '0;

    assign dm_rsp_valid = rsp_any && (owner == OWN_DM);
    assign dm_err       = wd_fire && (owner == OWN_DM);
    assign dm_rdata     = (rsp_data && (owner == OWN_DM)) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked against a fairness rule and a byte-addressed memory model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req_valid, dm_we, dm_req_ready, dm_rsp_valid, dm_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: who was granted last and what memory holds.
    bit          lastWasIf = 1'b0;
    logic [31:0] memModel [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_addr       (if_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .if_err        (if_err),
        .dm_req_valid  (dm_req_valid),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_wstrb      (dm_wstrb),
        .dm_req_ready  (dm_req_ready),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rdata      (dm_rdata),
        .dm_err        (dm_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One complete transaction: offer the requests, predict the winner, walk
    // REQ with readyDelay stalls, then WAIT until the response or the watchdog.
    task automatic applyStimulus(input bit ifv, input bit dmv,
                                 input logic [31:0] ifa, input logic [31:0] dma,
                                 input bit we, input logic [31:0] wd, input logic [3:0] ws,
                                 input int readyDelay, input int rspDelay);
        bit          winIf, rspNow, toNow, expV;
        logic [31:0] expAddr, expWdata, rd, cur;
        logic [3:0]  expStrb;
        bit          expWe;

        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;
        if_req_valid  = ifv;
        if_addr       = ifa;
        dm_req_valid  = dmv;
        dm_we         = we;
        dm_addr       = dma;
        dm_wdata      = wd;
        dm_wstrb      = ws;
        winIf = ifv && (!dmv || !lastWasIf);
        #1;
        checkOutput("if_req_ready", 32'(if_req_ready), 32'(winIf));
        checkOutput("dm_req_ready", 32'(dm_req_ready), 32'(!winIf));
        lastWasIf = winIf;
        expAddr  = winIf ? ifa : dma;
        expWe    = winIf ? 1'b0 : we;
        expStrb  = winIf ? 4'h0 : ws;
        expWdata = wd;

        for (int i = 0; i <= readyDelay; i++) begin
            @(negedge clk);
            if (winIf) begin
                if_req_valid = 1'b0;
                if_addr      = $urandom;
            end else begin
                dm_req_valid = 1'b0;
                dm_addr      = $urandom;
                dm_wdata     = $urandom;
                dm_wstrb     = 4'($urandom);
                dm_we        = 1'($urandom);
            end
            mem_req_ready = (i == readyDelay);
            #1;
            checkOutput("req_mem_valid", 32'(mem_req_valid), 32'd1);
            checkOutput("req_mem_addr", mem_addr, expAddr);
            checkOutput("req_mem_we", 32'(mem_we), 32'(expWe));
            checkOutput("req_mem_wstrb", 32'(mem_wstrb), 32'(expStrb));
            if (!winIf) checkOutput("req_mem_wdata", mem_wdata, expWdata);
            checkOutput("req_if_ready_low", 32'(if_req_ready), 32'd0);
            checkOutput("req_dm_ready_low", 32'(dm_req_ready), 32'd0);
        end

        for (int j = 0; j < TO; j++) begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            rspNow = (j == rspDelay);
            toNow  = !rspNow && (j == TO - 1);
            rd     = (winIf || !expWe) ? memRead(expAddr) : $urandom;
            mem_rsp_valid = rspNow;
            mem_rdata     = rspNow ? rd : $urandom;
            expV = rspNow || toNow;
            #1;
            checkOutput("wait_mem_valid", 32'(mem_req_valid), 32'd0);
            checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'(winIf && expV));
            checkOutput("dm_rsp_valid", 32'(dm_rsp_valid), 32'(!winIf && expV));
            checkOutput("if_err", 32'(if_err), 32'(winIf && toNow));
            checkOutput("dm_err", 32'(dm_err), 32'(!winIf && toNow));
            if (winIf) begin
                checkOutput("dm_rdata_idle", dm_rdata, 32'd0);
                if (expV) checkOutput("if_rdata", if_rdata, rspNow ? rd : 32'd0);
            end else begin
                checkOutput("if_rdata_idle", if_rdata, 32'd0);
                if (expV) checkOutput("dm_rdata", dm_rdata, rspNow ? rd : 32'd0);
            end
            if (rspNow && !winIf && expWe) begin
                cur = memRead(expAddr);
                for (int b = 0; b < 4; b++)
                    if (expStrb[b]) cur[8*b +: 8] = expWdata[8*b +: 8];
                memModel[expAddr] = cur;
            end
            if (expV) break;
        end
    endtask

    initial begin
        reset = 1'b1;
        if_req_valid = 1'b0; if_addr = '0;
        dm_req_valid = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        checkOutput("rst_dm_rsp_valid", 32'(dm_rsp_valid), 32'd0);
        checkOutput("rst_if_err", 32'(if_err), 32'd0);
        checkOutput("rst_dm_err", 32'(dm_err), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lastWasIf = 1'b0;

        $display("[TB] single fetch");
        memModel[32'h100] = 32'hDEADBEEF;
        applyStimulus(1, 0, 32'h100, 32'h0, 0, 32'h0, 4'h0, 0, 0);

        $display("[TB] contention IF/DM alternation");
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 1, 32'h0, 32'h2000, 0, 32'h0, 4'h0, 0, 0);

        $display("[TB] store with backpressure, then read back");
        applyStimulus(0, 1, 32'h0, 32'h40, 1, 32'h12345678, 4'b0011, 3, 0);
        applyStimulus(0, 1, 32'h0, 32'h40, 0, 32'h0, 4'h0, 0, 1);

        $display("[TB] watchdog timeout and late response");
        applyStimulus(0, 1, 32'h0, 32'h80, 0, 32'h0, 4'h0, 0, 99);
        @(negedge clk);
        dm_req_valid  = 1'b0;
        if_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFEF00D;
        #1;
        checkOutput("late_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        checkOutput("late_dm_rsp_valid", 32'(dm_rsp_valid), 32'd0);
        checkOutput("late_dm_err", 32'(dm_err), 32'd0);
        checkOutput("late_mem_req_valid", 32'(mem_req_valid), 32'd0);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        dm_req_valid  = 1'b1;
        dm_we         = 1'b0;
        dm_addr       = 32'h300;
        #1;
        checkOutput("rw_dm_ready", 32'(dm_req_ready), 32'd1);
        @(negedge clk);
        dm_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("rw_mem_req_valid", 32'(mem_req_valid), 32'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        checkOutput("rw_in_wait_no_rsp", 32'(dm_rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0BADF00D;
        #1;
        checkOutput("rw_mem_req_valid_low", 32'(mem_req_valid), 32'd0);
        checkOutput("rw_dm_rsp_valid", 32'(dm_rsp_valid), 32'd0);
        checkOutput("rw_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        lastWasIf = 1'b0;
        applyStimulus(1, 1, 32'h44, 32'h48, 0, 32'h0, 4'h0, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 30; n++) begin
            bit ifv, dmv;
            ifv = 1'($urandom);
            dmv = 1'($urandom);
            if (!ifv && !dmv) ifv = 1'b1;
            applyStimulus(ifv, dmv,
                          {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                          {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                          1'($urandom), $urandom, 4'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 5));
        end

        @(negedge clk);
        if_req_valid  = 1'b0;
        dm_req_valid  = 1'b0;
        mem_rsp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
